// File: rtl/rackctl_txn_wbm.sv
// rackctl_txn_wbm: runs one Wishbone-classic single access per rackctl receive transaction.
// Optional: define RACKCTL_TXN_WBM_TIMEOUT_EN to build the access timeout counter and stat_o[2].
module rackctl_txn_wbm #(
    parameter int unsigned ADR_BITS = 22,
    parameter int unsigned TIMEOUT  = 96,
    parameter logic [31:0] ERR_RESP = 32'hBADACCE5
) (
    input  logic                rxclk_i,
    input  logic                rst_n_i,
    input  logic                txn_valid_i,
    input  logic [23:0]         txn_addr_i,
    input  logic [31:0]         txn_data_i,
    output logic                txn_done_o,
    output logic [31:0]         txn_resp_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    output logic                wb_we_o,
    output logic [ADR_BITS-1:0] wb_adr_o,
    output logic [31:0]         wb_dat_o,
    output logic [3:0]          wb_sel_o,
    input  logic [31:0]         wb_dat_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i,
    output logic [2:0]          stat_o,
    input  logic                stat_clr_i
);

    if (ADR_BITS == 0 || ADR_BITS > 22 || TIMEOUT == 0 || TIMEOUT >= 120) begin : g_param_check
        $error("rackctl_txn_wbm: ADR_BITS must be 1..22 and TIMEOUT 1..119");
    end

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t state;

    // Bit 22 and any address bits above ADR_BITS carry no meaning on the bus.
    logic unused_addr_bits;
    assign unused_addr_bits = ^txn_addr_i[22:ADR_BITS];

    assign wb_sel_o = 4'hF;

`ifdef RACKCTL_TXN_WBM_TIMEOUT_EN
    localparam logic [6:0] TMO_LAST = 7'(TIMEOUT - 1);
    logic [6:0] timer;
`endif

    logic       in_access;
    logic       term_ack;
    logic       term_err;
    logic       term_tmo;
    logic       term_any;
    logic [2:0] stat_set;

    always_comb begin
        // NOTE: every signal gets a value before any conditional override, so no latch is inferred.
        in_access = (state == ACCESS);
        term_ack  = in_access && wb_ack_i;
        term_err  = in_access && !wb_ack_i && wb_err_i;
        term_tmo  = 1'b0;
`ifdef RACKCTL_TXN_WBM_TIMEOUT_EN
        term_tmo  = in_access && !wb_ack_i && !wb_err_i && (timer == TMO_LAST);
`endif
        term_any  = term_ack || term_err || term_tmo;
        stat_set  = {term_tmo, term_err, txn_valid_i && (state != IDLE)};
    end

    // NOTE: non-blocking assignments only, so every output is a flop that updates together on the edge.
    always_ff @(posedge rxclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_adr_o   <= '0;
            wb_dat_o   <= 32'h0;
            txn_done_o <= 1'b0;
            txn_resp_o <= 32'h0;
            stat_o     <= 3'b000;
`ifdef RACKCTL_TXN_WBM_TIMEOUT_EN
            timer      <= 7'd0;
`endif
        end else begin
            txn_done_o <= 1'b0;
            // A set event in the same cycle as the clear survives it.
            stat_o     <= (stat_clr_i ? 3'b000 : stat_o) | stat_set;

            unique case (state)
                IDLE: begin
                    if (txn_valid_i) begin
                        wb_adr_o <= txn_addr_i[ADR_BITS-1:0];
                        wb_we_o  <= ~txn_addr_i[23];
                        wb_dat_o <= txn_data_i;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        state    <= ACCESS;
                    end
                end

                ACCESS: begin
`ifdef RACKCTL_TXN_WBM_TIMEOUT_EN
                    timer <= timer + 7'd1;
`endif
                    if (term_any) begin
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        txn_done_o <= 1'b1;
                        txn_resp_o <= term_ack ? (wb_we_o ? 32'h0 : wb_dat_i) : ERR_RESP;
                        state      <= DONE;
                    end
                end

                DONE: begin
`ifdef RACKCTL_TXN_WBM_TIMEOUT_EN
                    timer <= 7'd0;
`endif
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
